// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the load/store data-port RAM controller.
// The controller handles 32-bit words split into four byte lanes.
package ram_ctrl_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int WORD_W    = NUM_LANES * LANE_W;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RMW_WR,
        RESP
    } state_t;

    // Per-lane select: enabled lanes take new data, the rest keep the old word.
    function automatic logic [WORD_W-1:0] merge(
        input logic [WORD_W-1:0]    old_w,
        input logic [WORD_W-1:0]    new_w,
        input logic [NUM_LANES-1:0] be
    );
        logic [WORD_W-1:0] res;
        for (int k = 0; k < NUM_LANES; k++)
            res[k*LANE_W +: LANE_W] = be[k] ? new_w[k*LANE_W +: LANE_W]
                                            : old_w[k*LANE_W +: LANE_W];
        return res;
    endfunction

endpackage

// File: rtl/ram_ctrl_if.sv
// Load/store unit request/response bus (req/gnt/rvalid handshake).
// The master side belongs to the LSU; the slave side belongs to ram_ctrl.
interface ram_ctrl_if #(
    parameter int DWIDTH = 32
);
    logic              req_i;
    logic              gnt_o;
    logic              we_i;
    logic [3:0]        be_i;
    logic [31:0]       addr_i;
    logic [DWIDTH-1:0] wdata_i;
    logic              rvalid_o;
    logic [DWIDTH-1:0] rdata_o;
    logic              err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/ram_byte_merge.sv
// Combinational byte-lane mux that builds the write word of a read-modify-write.
module ram_byte_merge
    import ram_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0]    i_old,
    input  logic [WORD_W-1:0]    i_new,
    input  logic [NUM_LANES-1:0] i_be,
    output logic [WORD_W-1:0]    o_data
);

    assign o_data = merge(i_old, i_new, i_be);

endmodule

// File: rtl/ram_ctrl.sv
// Data-port controller: decodes a base-address window and turns byte-enabled
// requests into word RAM accesses, with read-modify-write for sub-word stores.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int          AWIDTH    = 8,
    parameter int          DWIDTH    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    ram_ctrl_if.slave         bus,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [31:0]       mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    state_t              r_state;
    state_t              w_next;
    logic                r_we;
    logic [3:0]          r_be;
    logic [AWIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]   r_wdata;
    logic                r_hit;
    logic [DWIDTH-1:0]   r_old;
    logic [DWIDTH-1:0]   r_rdata;

    logic                w_accept;
    logic                w_hit_in;
    logic                w_full;
    logic                w_partial;
    logic [DWIDTH-1:0]   w_merged;
    logic [31:0]         w_word_addr;
    logic                w_unused;

    assign w_accept    = bus.gnt_o;
    assign w_hit_in    = bus.addr_i[31:AWIDTH+2] == BASE_ADDR[31:AWIDTH+2];
    assign w_full      = r_we && (r_be == 4'hF);
    assign w_partial   = r_we && (r_be != 4'h0) && (r_be != 4'hF);
    assign w_word_addr = {{(32-AWIDTH){1'b0}}, r_addr};
    assign w_unused    = ^bus.addr_i[1:0];

    ram_byte_merge u_merge (
        .i_old  (r_old),
        .i_new  (r_wdata),
        .i_be   (r_be),
        .o_data (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_i) w_next = w_hit_in ? ACCESS : RESP;
            ACCESS:  w_next = w_partial ? RMW_WR : RESP;
            RMW_WR:  w_next = RESP;
            RESP:    w_next = bus.req_i ? (w_hit_in ? ACCESS : RESP) : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Read cycles put the current word back on mem_wdata so the RAM sees no change.
    always_comb begin
        bus.gnt_o    = 1'b0;
        bus.rvalid_o = 1'b0;
        bus.err_o    = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = '0;
        case (r_state)
            IDLE: bus.gnt_o = bus.req_i;
            ACCESS: begin
                mem_en    = 1'b1;
                mem_wr    = w_full;
                mem_addr  = w_word_addr;
                mem_wdata = w_full ? r_wdata : mem_rdata;
            end
            RMW_WR: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = w_word_addr;
                mem_wdata = w_merged;
            end
            RESP: begin
                bus.gnt_o    = bus.req_i;
                bus.rvalid_o = 1'b1;
                bus.err_o    = ~r_hit;
            end
            default: ;
        endcase
    end

    assign bus.rdata_o = r_rdata;

    // r_rdata only moves when a response is about to be presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hit   <= 1'b0;
            r_old   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.we_i;
                r_be    <= bus.be_i;
                r_addr  <= bus.addr_i[AWIDTH+1:2];
                r_wdata <= bus.wdata_i;
                r_hit   <= w_hit_in;
                if (!w_hit_in) r_rdata <= '0;
            end
            if (r_state == ACCESS) begin
                r_old <= mem_rdata;
                if (!w_partial) r_rdata <= mem_rdata;
            end
            if (r_state == RMW_WR) r_rdata <= r_old;
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: directed scenarios plus random traffic
// against a transaction-level memory model.
module tb_ram_ctrl;

    localparam int          AW   = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] ram [256] = '{default: 32'h0};
    logic [31:0] ref_mem [256];

    int n_chk = 0;
    int n_err = 0;
    int wr_cnt = 0, en_cnt = 0, rv_cnt = 0;

    int          wr0, rv0, ng, nr;
    int          gcyc [3];
    logic [31:0] exp_b [3];

    ram_ctrl_if #(.DWIDTH(32)) bus ();

    ram_ctrl #(.AWIDTH(AW), .DWIDTH(32), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[AW-1:0]];

    always @(posedge clk) begin
        if (mem_en && mem_wr) ram[mem_addr[AW-1:0]] <= mem_wdata;
        if (mem_en) en_cnt <= en_cnt + 1;
        if (mem_en && mem_wr) wr_cnt <= wr_cnt + 1;
        if (bus.rvalid_o) rv_cnt <= rv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >> (AW + 2)) == (BASE >> (AW + 2));
    endfunction

    // One complete request: predicts response from the model, then drives and checks.
    task automatic xact(input string tag, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd);
        bit          hit, got_gnt, got_rv;
        int          idx, lat, exp_lat, exp_wr, exp_en, w0, e0;
        logic [31:0] exp_rd;
        hit     = in_win(addr);
        idx     = int'(addr[AW+1:2]);
        exp_rd  = hit ? ref_mem[idx] : 32'h0;
        exp_lat = !hit ? 1 : ((we && be != 4'h0 && be != 4'hF) ? 3 : 2);
        exp_wr  = (hit && we && be != 4'h0) ? 1 : 0;
        exp_en  = hit ? exp_lat - 1 : 0;
        if (exp_wr != 0)
            for (int k = 0; k < 4; k++)
                if (be[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];

        @(negedge clk);
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.be_i    = be;
        bus.addr_i  = addr;
        bus.wdata_i = wd;
        got_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.gnt_o) begin got_gnt = 1'b1; break; end
            @(negedge clk);
        end
        chk({tag, " gnt"}, 32'(got_gnt), 32'd1);
        w0 = wr_cnt;
        e0 = en_cnt;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        chk({tag, " mem_addr"}, mem_addr, hit ? 32'(idx) : 32'h0);
        chk({tag, " mem_wr1"}, 32'(mem_wr), 32'(hit && we && be == 4'hF));
        lat = 1;
        got_rv = 1'b0;
        while (lat <= 6) begin
            if (bus.rvalid_o) begin got_rv = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " rvalid"}, 32'(got_rv), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " rdata"}, bus.rdata_o, exp_rd);
        chk({tag, " err"}, 32'(bus.err_o), 32'(!hit));
        chk({tag, " writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
        chk({tag, " ram_cycles"}, 32'(en_cnt - e0), 32'(exp_en));
        if (hit) chk({tag, " ram_word"}, ram[idx], ref_mem[idx]);
        @(posedge clk); #1;
        chk({tag, " rvalid_pulse"}, 32'(bus.rvalid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.be_i    = 4'h0;
        bus.addr_i  = 32'h0;
        bus.wdata_i = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

        #12;
        chk("rst gnt", 32'(bus.gnt_o), 32'd0);
        chk("rst rvalid", 32'(bus.rvalid_o), 32'd0);
        chk("rst err", 32'(bus.err_o), 32'd0);
        chk("rst rdata", bus.rdata_o, 32'h0);
        chk("rst mem_en", 32'(mem_en), 32'd0);
        chk("rst mem_wr", 32'(mem_wr), 32'd0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        xact("st_full", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        xact("ld_full", 1'b0, 4'hF, 32'h10, 32'h0);
        xact("st_part", 1'b1, 4'b0010, 32'h10, 32'h0000_5500);
        chk("rmw word", ram[4], 32'hDEAD55EF);
        xact("ld_part", 1'b0, 4'hF, 32'h10, 32'h0);
        xact("ld_miss", 1'b0, 4'hF, 32'h0000_0400, 32'h0);

        // Back-to-back loads with req held.
        for (int i = 0; i < 3; i++) begin
            exp_b[i] = 32'hA000_0000 + 32'(i * 16 + 7);
            xact("b2b_pre", 1'b1, 4'hF, 32'(i * 4), exp_b[i]);
        end
        @(negedge clk);
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.be_i   = 4'hF;
        bus.addr_i = 32'h0;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 20 && nr < 3; c++) begin
            #1;
            if (bus.rvalid_o) begin
                if (nr < ng) chk("b2b rv_cycle", 32'(c), 32'(gcyc[nr] + 2));
                chk("b2b rdata", bus.rdata_o, exp_b[nr]);
                nr++;
            end
            if (bus.gnt_o && ng < 3) begin
                gcyc[ng] = c;
                ng++;
                @(posedge clk); #1;
                if (ng < 3) bus.addr_i = 32'(ng * 4);
                else        bus.req_i  = 1'b0;
            end
            @(negedge clk);
        end
        bus.req_i = 1'b0;
        chk("b2b responses", 32'(nr), 32'd3);
        chk("b2b gnt_gap1", 32'(gcyc[1] - gcyc[0]), 32'd2);
        chk("b2b gnt_gap2", 32'(gcyc[2] - gcyc[1]), 32'd2);

        // Reset while the RMW write is on the RAM bus.
        xact("rst_pre", 1'b1, 4'hF, 32'h30, 32'h11223344);
        @(negedge clk);
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.be_i    = 4'b0001;
        bus.addr_i  = 32'h30;
        bus.wdata_i = 32'h0000_00AA;
        #1;
        chk("rst_rmw gnt", 32'(bus.gnt_o), 32'd1);
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_rmw in_write", 32'(mem_wr), 32'd1);
        wr0 = wr_cnt;
        rv0 = rv_cnt;
        rst = 1'b1;
        #1;
        chk("rst_rmw mem_en", 32'(mem_en), 32'd0);
        chk("rst_rmw mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_rmw mem_addr", mem_addr, 32'h0);
        chk("rst_rmw mem_wdata", mem_wdata, 32'h0);
        chk("rst_rmw rvalid", 32'(bus.rvalid_o), 32'd0);
        chk("rst_rmw rdata", bus.rdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rmw no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("rst_rmw no_rvalid", 32'(rv_cnt - rv0), 32'd0);
        xact("rst_post_ld", 1'b0, 4'hF, 32'h30, 32'h0);
        chk("rst_post word", ram[12], 32'h11223344);

        xact("be0_pre", 1'b1, 4'hF, 32'h20, 32'h12345678);
        xact("be0_st", 1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF);
        chk("be0 word", ram[8], 32'h12345678);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a, d;
            logic [3:0]  b;
            logic        w;
            w = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            d = $urandom;
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_0400;
            else                           a = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            xact("rand", w, b, a, d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
